// File: rtl/ex_operand_if.sv
// ID/EX operand bundle: ID-side inputs, forwarding sources and EX-side outputs.
// The slave modport is the EX operand stage itself.
interface ex_operand_if;
  logic        id_valid;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [31:0] id_imm;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [5:0]  id_funct;
  logic [1:0]  id_aluop;
  logic        id_alusrc;
  logic        id_regdst;
  logic        id_regwrite;
  logic        id_memread;
  logic        id_memwrite;
  logic        id_memtoreg;
  logic        hold;
  logic        flush;
  logic        mem_regwrite;
  logic        wb_regwrite;
  logic [4:0]  mem_rd;
  logic [4:0]  wb_rd;
  logic [31:0] mem_result;
  logic [31:0] wb_result;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_ctrl;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_wdest;
  logic        ex_valid;
  logic        ex_regwrite;
  logic        ex_memread;
  logic        ex_memwrite;
  logic        ex_memtoreg;
  logic        load_use_hazard;

  modport slave (
    input  id_valid, id_rs_data, id_rt_data, id_imm,
    input  id_rs, id_rt, id_rd, id_funct, id_aluop,
    input  id_alusrc, id_regdst, id_regwrite,
    input  id_memread, id_memwrite, id_memtoreg,
    input  hold, flush,
    input  mem_regwrite, wb_regwrite, mem_rd, wb_rd,
    input  mem_result, wb_result,
    output alu_a, alu_b, alu_ctrl, ex_store_data,
    output ex_wdest, ex_valid, ex_regwrite,
    output ex_memread, ex_memwrite, ex_memtoreg,
    output load_use_hazard
  );

  modport master (
    output id_valid, id_rs_data, id_rt_data, id_imm,
    output id_rs, id_rt, id_rd, id_funct, id_aluop,
    output id_alusrc, id_regdst, id_regwrite,
    output id_memread, id_memwrite, id_memtoreg,
    output hold, flush,
    output mem_regwrite, wb_regwrite, mem_rd, wb_rd,
    output mem_result, wb_result,
    input  alu_a, alu_b, alu_ctrl, ex_store_data,
    input  ex_wdest, ex_valid, ex_regwrite,
    input  ex_memread, ex_memwrite, ex_memtoreg,
    input  load_use_hazard
  );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with ALU-control decode, operand forwarding
// from MEM/WB and load-use hazard detection.
module ex_operand_stage (
  input logic         clk,
  input logic         rst_n,
  ex_operand_if.slave bus
);

  typedef struct packed {
    logic        valid;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wdest;
    logic        alusrc;
    logic [2:0]  alu_ctrl;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
  } ex_t;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam ex_t BUBBLE = '{alu_ctrl: ALU_ADD, default: '0};

  ex_t         ex_q;
  ex_t         ex_d;
  logic [2:0]  dec;
  logic [31:0] fwd_a;
  logic [31:0] fwd_b;
  logic        hazard;
  logic        v;

  function automatic logic [31:0] fwd(
    input logic [4:0]  r,
    input logic [31:0] dflt
  );
    logic [31:0] res;
    res = dflt;
    if (bus.mem_regwrite && bus.mem_rd != 5'd0 && bus.mem_rd == r)
      res = bus.mem_result;
    else if (bus.wb_regwrite && bus.wb_rd != 5'd0 && bus.wb_rd == r)
      res = bus.wb_result;
    return res;
  endfunction

  always_comb begin
    dec = ALU_ADD;
    unique case (1'b1)
      bus.id_aluop == 2'b01: dec = 3'b110;
      bus.id_aluop == 2'b11: dec = 3'b001;
      bus.id_aluop == 2'b10: begin
        unique case (bus.id_funct)
          6'b100010: dec = 3'b110;
          6'b100100: dec = 3'b000;
          6'b100101: dec = 3'b001;
          6'b101010: dec = 3'b111;
          default:   dec = ALU_ADD;
        endcase
      end
      default: dec = ALU_ADD;
    endcase
  end

  assign fwd_a = fwd(ex_q.rs, ex_q.rs_data);
  assign fwd_b = fwd(ex_q.rt, ex_q.rt_data);

  assign hazard = ex_q.valid & ex_q.memread
                & (ex_q.rt != 5'd0) & bus.id_valid
                & ((ex_q.rt == bus.id_rs) | (ex_q.rt == bus.id_rt));

  assign v = bus.id_valid;

  always_comb begin
    ex_d = ex_q;
    priority case (1'b1)
      bus.flush: ex_d = BUBBLE;
      // Freeze, but keep forwarded operands alive past their source.
      bus.hold: begin
        ex_d.rs_data = fwd_a;
        ex_d.rt_data = fwd_b;
      end
      hazard: ex_d = BUBBLE;
      default: begin
        ex_d.valid    = v;
        ex_d.rs_data  = bus.id_rs_data;
        ex_d.rt_data  = bus.id_rt_data;
        ex_d.imm      = bus.id_imm;
        ex_d.rs       = bus.id_rs;
        ex_d.rt       = bus.id_rt;
        ex_d.wdest    = bus.id_regdst ? bus.id_rd : bus.id_rt;
        ex_d.alusrc   = bus.id_alusrc & v;
        ex_d.alu_ctrl = dec;
        ex_d.regwrite = bus.id_regwrite & v;
        ex_d.memread  = bus.id_memread & v;
        ex_d.memwrite = bus.id_memwrite & v;
        ex_d.memtoreg = bus.id_memtoreg & v;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_q <= BUBBLE;
    else        ex_q <= ex_d;
  end

  assign bus.alu_a           = fwd_a;
  assign bus.alu_b           = ex_q.alusrc ? ex_q.imm : fwd_b;
  assign bus.alu_ctrl        = ex_q.alu_ctrl;
  assign bus.ex_store_data   = fwd_b;
  assign bus.ex_wdest        = ex_q.wdest;
  assign bus.ex_valid        = ex_q.valid;
  assign bus.ex_regwrite     = ex_q.regwrite;
  assign bus.ex_memread      = ex_q.memread;
  assign bus.ex_memwrite     = ex_q.memwrite;
  assign bus.ex_memtoreg     = ex_q.memtoreg;
  assign bus.load_use_hazard = hazard;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: random traffic against a behavioural model
// plus directed cases with hand-computed values.
module tb_ex_operand_stage;

  logic clk = 1'b0;
  logic rst_n;
  logic run = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  ex_operand_if bus ();

  ex_operand_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          valid;
    bit [31:0]   rs_data;
    bit [31:0]   rt_data;
    bit [31:0]   imm;
    bit [4:0]    rs;
    bit [4:0]    rt;
    bit [4:0]    wd;
    bit          alusrc;
    bit [2:0]    ctrl;
    bit          rw;
    bit          mr;
    bit          mw;
    bit          mt;
  } m_t;

  m_t m;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic m_t bubble();
    m_t b;
    b = '{default: 0};
    b.ctrl = 3'd2;
    return b;
  endfunction

  function automatic bit [2:0] alu_of(input bit [1:0] op,
                                      input bit [5:0] f);
    if (op == 2'd0) return 3'd2;
    if (op == 2'd1) return 3'd6;
    if (op == 2'd3) return 3'd1;
    if (f == 6'd32) return 3'd2;
    if (f == 6'd34) return 3'd6;
    if (f == 6'd36) return 3'd0;
    if (f == 6'd37) return 3'd1;
    if (f == 6'd42) return 3'd7;
    return 3'd2;
  endfunction

  function automatic bit [31:0] fwd(input bit [4:0] r,
                                    input bit [31:0] d);
    if (bus.mem_regwrite && bus.mem_rd != 0 && bus.mem_rd == r)
      return bus.mem_result;
    if (bus.wb_regwrite && bus.wb_rd != 0 && bus.wb_rd == r)
      return bus.wb_result;
    return d;
  endfunction

  function automatic bit hz(input m_t c);
    return c.valid && c.mr && c.rt != 0 && bus.id_valid &&
           (c.rt == bus.id_rs || c.rt == bus.id_rt);
  endfunction

  function automatic m_t next_m(input m_t c);
    m_t n;
    bit v;
    n = c;
    v = bus.id_valid;
    if (bus.flush) return bubble();
    if (bus.hold) begin
      n.rs_data = fwd(c.rs, c.rs_data);
      n.rt_data = fwd(c.rt, c.rt_data);
      return n;
    end
    if (hz(c)) return bubble();
    n.valid   = v;
    n.rs_data = bus.id_rs_data;
    n.rt_data = bus.id_rt_data;
    n.imm     = bus.id_imm;
    n.rs      = bus.id_rs;
    n.rt      = bus.id_rt;
    n.wd      = bus.id_regdst ? bus.id_rd : bus.id_rt;
    n.alusrc  = bus.id_alusrc & v;
    n.ctrl    = alu_of(bus.id_aluop, bus.id_funct);
    n.rw      = bus.id_regwrite & v;
    n.mr      = bus.id_memread & v;
    n.mw      = bus.id_memwrite & v;
    n.mt      = bus.id_memtoreg & v;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= bubble();
    else        m <= next_m(m);
  end

  always @(negedge clk) begin
    if (run) begin
      bit [31:0] b;
      b = fwd(m.rt, m.rt_data);
      chk("alu_a", bus.alu_a, fwd(m.rs, m.rs_data));
      chk("alu_b", bus.alu_b, m.alusrc ? m.imm : b);
      chk("store_data", bus.ex_store_data, b);
      chk("alu_ctrl", 32'(bus.alu_ctrl), 32'(m.ctrl));
      chk("wdest", 32'(bus.ex_wdest), 32'(m.wd));
      chk("flags",
          32'({bus.ex_valid, bus.ex_regwrite, bus.ex_memread,
               bus.ex_memwrite, bus.ex_memtoreg}),
          32'({m.valid, m.rw, m.mr, m.mw, m.mt}));
      chk("hazard", 32'(bus.load_use_hazard), 32'(hz(m)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    bus.id_valid = 0; bus.id_rs_data = 0; bus.id_rt_data = 0;
    bus.id_imm = 0; bus.id_rs = 0; bus.id_rt = 0; bus.id_rd = 0;
    bus.id_funct = 0; bus.id_aluop = 0; bus.id_alusrc = 0;
    bus.id_regdst = 0; bus.id_regwrite = 0; bus.id_memread = 0;
    bus.id_memwrite = 0; bus.id_memtoreg = 0; bus.hold = 0;
    bus.flush = 0; bus.mem_regwrite = 0; bus.wb_regwrite = 0;
    bus.mem_rd = 0; bus.wb_rd = 0; bus.mem_result = 0;
    bus.wb_result = 0;
  endtask

  task automatic alu_instr(input bit [4:0] rs, input bit [31:0] rsd);
    clear();
    bus.id_valid = 1; bus.id_rs = rs; bus.id_rs_data = rsd;
    bus.id_rt = 5'd6; bus.id_rt_data = 32'h66;
    bus.id_regwrite = 1; bus.id_aluop = 2'd0;
  endtask

  task automatic rand_inputs();
    bit [5:0] fl [6];
    fl = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd7};
    bus.id_valid    = ($urandom % 8) != 0;
    bus.id_rs_data  = $urandom;
    bus.id_rt_data  = $urandom;
    bus.id_imm      = $urandom;
    bus.id_rs       = 5'($urandom % 8);
    bus.id_rt       = 5'($urandom % 8);
    bus.id_rd       = 5'($urandom % 8);
    bus.id_funct    = fl[$urandom % 6];
    bus.id_aluop    = 2'($urandom);
    bus.id_alusrc   = 1'($urandom);
    bus.id_regdst   = 1'($urandom);
    bus.id_regwrite = 1'($urandom);
    bus.id_memread  = ($urandom % 3) == 0;
    bus.id_memwrite = 1'($urandom);
    bus.id_memtoreg = 1'($urandom);
    bus.hold        = ($urandom % 6) == 0;
    bus.flush       = ($urandom % 10) == 0;
    bus.mem_regwrite = 1'($urandom);
    bus.wb_regwrite  = 1'($urandom);
    bus.mem_rd      = 5'($urandom % 8);
    bus.wb_rd       = 5'($urandom % 8);
    bus.mem_result  = $urandom;
    bus.wb_result   = $urandom;
  endtask

  initial begin
    clear();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    run = 1'b1;
    #6;
    chk("rst_alu_ctrl", 32'(bus.alu_ctrl), 32'd2);
    chk("rst_alu_a", bus.alu_a, 32'd0);
    chk("rst_valid", 32'(bus.ex_valid), 32'd0);
    #5 rst_n = 1'b1;

    // R-type sub
    clear();
    bus.id_valid = 1; bus.id_rs = 1; bus.id_rt = 2; bus.id_rd = 7;
    bus.id_rs_data = 10; bus.id_rt_data = 3; bus.id_aluop = 2'b10;
    bus.id_funct = 6'b100010; bus.id_regdst = 1; bus.id_regwrite = 1;
    tick();
    chk("sub_ctrl", 32'(bus.alu_ctrl), 32'd6);
    chk("sub_a", bus.alu_a, 32'd10);
    chk("sub_b", bus.alu_b, 32'd3);
    chk("sub_wdest", 32'(bus.ex_wdest), 32'd7);

    // double forwarding on rs=4
    alu_instr(5'd4, 32'h99);
    tick();
    bus.mem_regwrite = 1; bus.mem_rd = 4; bus.mem_result = 32'h11;
    bus.wb_regwrite = 1; bus.wb_rd = 4; bus.wb_result = 32'h22;
    #1 chk("fwd_mem_wins", bus.alu_a, 32'h11);
    bus.mem_regwrite = 0;
    #1 chk("fwd_wb", bus.alu_a, 32'h22);
    bus.wb_rd = 0;
    #1 chk("fwd_r0", bus.alu_a, 32'h99);

    // load-use
    clear();
    bus.id_valid = 1; bus.id_rs = 1; bus.id_rt = 5; bus.id_imm = 8;
    bus.id_memread = 1; bus.id_regwrite = 1; bus.id_memtoreg = 1;
    bus.id_alusrc = 1;
    tick();
    chk("lw_memread", 32'(bus.ex_memread), 32'd1);
    bus.id_rs = 5; bus.id_rt = 9; bus.id_memread = 0;
    bus.id_memtoreg = 0; bus.id_alusrc = 0; bus.id_aluop = 2'b10;
    bus.id_funct = 6'b100000;
    #1 chk("lu_hazard", 32'(bus.load_use_hazard), 32'd1);
    tick();
    chk("lu_valid", 32'(bus.ex_valid), 32'd0);
    chk("lu_regwrite", 32'(bus.ex_regwrite), 32'd0);
    chk("lu_ctrl", 32'(bus.alu_ctrl), 32'd2);

    // hold keeps a forwarded operand
    alu_instr(5'd3, 32'h5);
    tick();
    bus.wb_regwrite = 1; bus.wb_rd = 3; bus.wb_result = 32'hABCD;
    #1 chk("hold_fwd", bus.alu_a, 32'hABCD);
    bus.hold = 1;
    tick();
    bus.wb_regwrite = 0; bus.wb_result = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_persist", bus.alu_a, 32'hABCD);
    end

    // flush beats hold
    alu_instr(5'd2, 32'h42);
    tick();
    chk("pre_flush_valid", 32'(bus.ex_valid), 32'd1);
    bus.hold = 1; bus.flush = 1;
    tick();
    chk("flush_valid", 32'(bus.ex_valid), 32'd0);
    chk("flush_ctrl", 32'(bus.alu_ctrl), 32'd2);
    chk("flush_a", bus.alu_a, 32'd0);

    // async reset during hold
    alu_instr(5'd2, 32'h77);
    tick();
    bus.hold = 1;
    tick();
    chk("prerst_valid", 32'(bus.ex_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_a", bus.alu_a, 32'd0);
    chk("arst_valid", 32'(bus.ex_valid), 32'd0);
    chk("arst_ctrl", 32'(bus.alu_ctrl), 32'd2);
    chk("arst_regwrite", 32'(bus.ex_regwrite), 32'd0);
    chk("arst_hazard", 32'(bus.load_use_hazard), 32'd0);
    alu_instr(5'd3, 32'h1234);
    bus.id_regdst = 1; bus.id_rd = 9;
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
    chk("postrst_a", bus.alu_a, 32'h1234);
    chk("postrst_wdest", 32'(bus.ex_wdest), 32'd9);
    chk("postrst_valid", 32'(bus.ex_valid), 32'd1);

    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      tick();
    end

    @(negedge clk);
    run = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
